io_bridge: RTL

Memory-mapped I/O controller between the CPU data port and the board peripherals in the `mips` top. It owns the registers behind the address window 0x7f50–0x7f70:
- digital-tube register
- LED register
- DIP-switch read path
- key interrupt status
- a 4-entry UART transmit queue feeding the UART transmitter through a valid/ready handshake

It replaces ad-hoc decode logic in the top. The top now only wires CPU bus ports, board pins and `irq` (into `HWInt_TB[2]`) to this block.

---
 rtl/io_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge for the 0x7f50-0x7f70 peripheral window: tube, LED, DIP, keys, UART TX queue.
// Define IO_BRIDGE_UART_EN to build the UART transmit queue; without it UART_DATA/UART_STAT read 0 and tx is idle.
module io_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  input  logic [31:0] dip_n0,
  input  logic [31:0] dip_n1,
  input  logic [7:0]  key_n,
  output logic [31:0] tube_data,
  output logic [31:0] led_n,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam logic [31:0] ADDR_TUBE  = 32'h0000_7f50;
  localparam logic [31:0] ADDR_UDATA = 32'h0000_7f58;
  localparam logic [31:0] ADDR_USTAT = 32'h0000_7f5c;
  localparam logic [31:0] ADDR_DIP0  = 32'h0000_7f60;
  localparam logic [31:0] ADDR_DIP1  = 32'h0000_7f64;
  localparam logic [31:0] ADDR_KEY   = 32'h0000_7f68;
  localparam logic [31:0] ADDR_LED   = 32'h0000_7f70;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  logic        sel_tube, sel_udata, sel_stat, sel_dip0, sel_dip1, sel_key, sel_led;
  logic        wr_any;
  logic [31:0] led_reg;
  logic [31:0] stat_word;
  logic [31:0] rd_word;

  assign sel_tube  = (addr == ADDR_TUBE);
  assign sel_udata = (addr == ADDR_UDATA);
  assign sel_stat  = (addr == ADDR_USTAT);
  assign sel_dip0  = (addr == ADDR_DIP0);
  assign sel_dip1  = (addr == ADDR_DIP1);
  assign sel_key   = (addr == ADDR_KEY);
  assign sel_led   = (addr == ADDR_LED);
  assign wr_any    = |byteen;

  always_ff @(posedge clk) begin
    if (reset) begin
      tube_data <= '0;
      led_reg   <= '0;
    end else begin
      if (sel_tube && wr_any) tube_data <= merge_bytes(tube_data, wdata, byteen);
      if (sel_led && wr_any)  led_reg   <= merge_bytes(led_reg, wdata, byteen);
    end
  end

  assign led_n = ~led_reg;

  // Key path: p0/p1 synchronize the raw keys, p2 holds the previous pressed state for edge detect.
  logic [7:0] key_sync_p0, key_sync_p1, pressed_p2;
  logic [7:0] pending, pending_next, key_rise, key_clr;

  assign key_rise     = key_sync_p1 & ~pressed_p2;
  assign key_clr      = (sel_key && byteen[1]) ? wdata[15:8] : 8'h00;
  assign pending_next = (pending & ~key_clr) | key_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync_p0 <= '0;
      key_sync_p1 <= '0;
      pressed_p2  <= '0;
      pending     <= '0;
      irq         <= 1'b0;
    end else begin
      key_sync_p0 <= ~key_n;
      key_sync_p1 <= key_sync_p0;
      pressed_p2  <= key_sync_p1;
      pending     <= pending_next;
      irq         <= |pending_next;
    end
  end

`ifdef IO_BRIDGE_UART_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, empty, full, push, pop, accept;

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign push   = sel_udata && byteen[0];
  assign pop    = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      count <= count + CW'(1);
      else if (!accept && pop) count <= count - CW'(1);
      if (push && !accept)                  ovf <= 1'b1;
      else if (sel_stat && byteen[0])       ovf <= 1'b0;
    end
  end

  assign tx_valid  = !empty;
  assign tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign stat_word = 32'({count, 1'b0, ovf, full, empty});
`else
  logic unused_uart;
  assign unused_uart = ^{tx_ready, sel_udata};
  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h00;
  assign stat_word   = '0;
`endif

  always_comb begin
    rd_word = '0;
    if (sel_tube)      rd_word = tube_data;
    else if (sel_stat) rd_word = stat_word;
    else if (sel_dip0) rd_word = ~dip_n0;
    else if (sel_dip1) rd_word = ~dip_n1;
    else if (sel_key)  rd_word = {16'h0000, pending, key_sync_p1};
    else if (sel_led)  rd_word = led_reg;
  end

  // Read stage: rdata is the registered view of the addressed word.
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= rd_word;
  end

endmodule
